// File: rtl/z16_ctrl_fsm.sv
// Z16 multi-cycle control sequencer: fetch/decode/exec/mem/writeback with
// memory handshakes, an acknowledge watchdog and a retired-instruction count.
module z16_ctrl_fsm #(
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic [3:0]       i_opcode,
    input  logic             i_branch_taken,
    output logic             o_imem_req,
    input  logic             i_imem_ack,
    output logic             o_ir_we,
    output logic             o_dmem_req,
    output logic             o_dmem_we,
    input  logic             i_dmem_ack,
    output logic             o_rf_we,
    output logic             o_wb_sel,
    output logic             o_pc_we,
    output logic [1:0]       o_pc_sel,
    output logic             o_busy,
    output logic             o_halted,
    output logic             o_fault,
    output logic [2:0]       o_state,
    output logic [CNT_W-1:0] o_retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    // Wait counter holds completed request cycles: 0 .. ACK_TIMEOUT-1.
    localparam int unsigned WD_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);

    state_t            state, state_n;
    logic [WD_W-1:0]   wait_cnt;
    logic [CNT_W-1:0]  retired;
    logic              retire;
    logic              wd_hit;
    logic              ir_we, pc_we;
    logic [1:0]        pc_sel;

    logic op_addi, op_store, op_load, op_jump, op_branch, op_halt;
    assign op_addi   = (i_opcode == 4'hA);
    assign op_store  = (i_opcode == 4'hB);
    assign op_load   = (i_opcode == 4'hC);
    assign op_jump   = (i_opcode == 4'hD);
    assign op_branch = (i_opcode == 4'hE);
    assign op_halt   = (i_opcode == 4'hF);

    // Next state, retire strobe and the ack/opcode-qualified enables.
    always_comb begin
        state_n = state;
        retire  = 1'b0;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        pc_sel  = 2'd0;
        wd_hit  = (ACK_TIMEOUT != 0) && (wait_cnt == WD_LAST);
        case (state)
            S_IDLE:   if (i_run) state_n = S_FETCH;
            S_FETCH: begin
                if (i_imem_ack) begin
                    ir_we   = 1'b1;
                    state_n = S_DECODE;
                end else if (wd_hit) begin
                    state_n = S_FAULT;
                end
            end
            S_DECODE: begin
                if (op_halt) begin
                    retire  = 1'b1;
                    state_n = S_HALT;
                end else begin
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                if (op_jump) begin
                    pc_we   = 1'b1;
                    pc_sel  = 2'd2;
                    retire  = 1'b1;
                    state_n = S_FETCH;
                end else if (op_branch) begin
                    pc_we   = 1'b1;
                    pc_sel  = {1'b0, i_branch_taken};
                    retire  = 1'b1;
                    state_n = S_FETCH;
                end else if (op_load || op_store) begin
                    state_n = S_MEM;
                end else begin
                    state_n = S_WB;
                end
            end
            S_MEM: begin
                if (i_dmem_ack) begin
                    if (op_store) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_n = S_FETCH;
                    end else begin
                        state_n = S_WB;
                    end
                end else if (wd_hit) begin
                    state_n = S_FAULT;
                end
            end
            S_WB: begin
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_n = S_FETCH;
            end
            S_HALT:   state_n = S_HALT;
            S_FAULT:  state_n = S_FAULT;
            default:  state_n = S_IDLE;
        endcase
    end

    // State, counters and Moore outputs; the Moore outputs are registered
    // from the next state so they line up exactly with the state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            retired    <= '0;
            o_imem_req <= 1'b0;
            o_dmem_req <= 1'b0;
            o_dmem_we  <= 1'b0;
            o_rf_we    <= 1'b0;
            o_wb_sel   <= 1'b0;
            o_busy     <= 1'b0;
            o_halted   <= 1'b0;
            o_fault    <= 1'b0;
        end else begin
            state <= state_n;
            if (retire) retired <= retired + CNT_W'(1);
            if ((state == S_FETCH || state == S_MEM) && state_n == state)
                wait_cnt <= wait_cnt + WD_W'(1);
            else
                wait_cnt <= '0;
            o_imem_req <= (state_n == S_FETCH);
            o_dmem_req <= (state_n == S_MEM);
            o_dmem_we  <= (state_n == S_MEM) && op_store;
            o_rf_we    <= (state_n == S_WB);
            o_wb_sel   <= (state_n == S_WB) && op_load;
            o_busy     <= !(state_n == S_IDLE || state_n == S_HALT || state_n == S_FAULT);
            o_halted   <= (state_n == S_HALT);
            o_fault    <= (state_n == S_FAULT);
        end
    end

    assign o_ir_we   = ir_we;
    assign o_pc_we   = pc_we;
    assign o_pc_sel  = pc_sel;
    assign o_state   = state;
    assign o_retired = retired;

endmodule

// File: tb/tb_z16_ctrl_fsm.sv
// Directed bench for z16_ctrl_fsm (ACK_TIMEOUT=4, CNT_W=2).
module tb_z16_ctrl_fsm;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_run = 1'b0;
    logic [3:0] i_opcode = 4'h0;
    logic       i_branch_taken = 1'b0;
    logic       i_imem_ack = 1'b0;
    logic       i_dmem_ack = 1'b0;
    logic       o_imem_req, o_ir_we, o_dmem_req, o_dmem_we, o_rf_we, o_wb_sel;
    logic       o_pc_we, o_busy, o_halted, o_fault;
    logic [1:0] o_pc_sel;
    logic [2:0] o_state;
    logic [1:0] o_retired;
    logic [16:0] outs;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    z16_ctrl_fsm #(.ACK_TIMEOUT(4), .CNT_W(2)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_run(i_run), .i_opcode(i_opcode),
        .i_branch_taken(i_branch_taken), .o_imem_req(o_imem_req),
        .i_imem_ack(i_imem_ack), .o_ir_we(o_ir_we), .o_dmem_req(o_dmem_req),
        .o_dmem_we(o_dmem_we), .i_dmem_ack(i_dmem_ack), .o_rf_we(o_rf_we),
        .o_wb_sel(o_wb_sel), .o_pc_we(o_pc_we), .o_pc_sel(o_pc_sel),
        .o_busy(o_busy), .o_halted(o_halted), .o_fault(o_fault),
        .o_state(o_state), .o_retired(o_retired)
    );

    assign outs = {o_imem_req, o_ir_we, o_dmem_req, o_dmem_we, o_rf_we, o_wb_sel,
                   o_pc_we, o_pc_sel, o_busy, o_halted, o_fault, o_state, o_retired};

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset;
        i_rst = 1'b1; i_run = 1'b0; i_imem_ack = 1'b0; i_dmem_ack = 1'b0;
        i_opcode = 4'h0; i_branch_taken = 1'b0;
        tick; tick;
        i_rst = 1'b0;
        #1;
        check("rst_state", o_state, 0);
        check("rst_outs", outs, 0);
    endtask

    task automatic start;
        i_run = 1'b1;
        tick;
        i_run = 1'b0;
        #1;
        check("start_state", o_state, 1);
        check("start_req", o_imem_req, 1);
    endtask

    // Runs one instruction from FETCH entry; expects to end in FETCH (or HALT).
    task automatic do_instr(input logic [3:0] op, input int iwait, input int dwait,
                            input logic taken, input int unsigned exp_sel,
                            input int unsigned exp_lat);
        int unsigned cyc = 0;
        for (int i = 0; i < iwait; i++) begin
            i_imem_ack = 1'b0;
            #1;
            check("f_wait_req", o_imem_req, 1);
            check("f_wait_irwe", o_ir_we, 0);
            tick; cyc++;
        end
        i_imem_ack = 1'b1;
        #1;
        check("f_state", o_state, 1);
        check("f_req", o_imem_req, 1);
        check("f_irwe", o_ir_we, 1);
        tick; cyc++;
        i_imem_ack = 1'b0; i_opcode = op; i_branch_taken = taken;
        #1;
        check("d_state", o_state, 2);
        check("d_req", o_imem_req, 0);
        check("d_irwe", o_ir_we, 0);
        check("d_busy", o_busy, 1);
        tick; cyc++;
        if (op == 4'hF) begin
            #1;
            check("h_state", o_state, 6);
            check("h_halted", o_halted, 1);
            check("h_busy", o_busy, 0);
            check("lat", cyc, exp_lat);
        end else begin
            #1;
            check("x_state", o_state, 3);
            check("x_rfwe", o_rf_we, 0);
            if (op == 4'hD || op == 4'hE) begin
                check("x_pcwe", o_pc_we, 1);
                check("x_pcsel", o_pc_sel, exp_sel);
            end else begin
                check("x_pcwe", o_pc_we, 0);
                check("x_pcsel", o_pc_sel, 0);
            end
            tick; cyc++;
            if (op == 4'hB || op == 4'hC) begin
                for (int i = 0; i < dwait; i++) begin
                    #1;
                    check("m_wait_state", o_state, 4);
                    check("m_wait_req", o_dmem_req, 1);
                    check("m_wait_we", o_dmem_we, (op == 4'hB) ? 1 : 0);
                    check("m_wait_pcwe", o_pc_we, 0);
                    check("m_wait_rfwe", o_rf_we, 0);
                    tick; cyc++;
                end
                i_dmem_ack = 1'b1;
                #1;
                check("m_state", o_state, 4);
                check("m_req", o_dmem_req, 1);
                check("m_we", o_dmem_we, (op == 4'hB) ? 1 : 0);
                check("m_pcwe", o_pc_we, (op == 4'hB) ? 1 : 0);
                check("m_pcsel", o_pc_sel, exp_sel);
                tick; cyc++;
                i_dmem_ack = 1'b0;
            end
            if (op <= 4'hA || op == 4'hC) begin
                #1;
                check("w_state", o_state, 5);
                check("w_rfwe", o_rf_we, 1);
                check("w_wbsel", o_wb_sel, (op == 4'hC) ? 1 : 0);
                check("w_pcwe", o_pc_we, 1);
                check("w_pcsel", o_pc_sel, 0);
                check("w_dreq", o_dmem_req, 0);
                tick; cyc++;
            end
            #1;
            check("next_fetch", o_state, 1);
            check("next_dreq", o_dmem_req, 0);
            check("next_rfwe", o_rf_we, 0);
            check("lat", cyc, exp_lat);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation ran past its time limit");
        $fatal(1, "time limit");
    end

    initial begin
        // ADDI, immediate ack
        do_reset;
        start;
        do_instr(4'hA, 0, 0, 1'b0, 0, 4);
        check("addi_retired", o_retired, 1);

        // LOAD with dmem ack on the third request cycle
        do_reset;
        start;
        do_instr(4'hC, 0, 2, 1'b0, 0, 7);
        check("load_retired", o_retired, 1);

        // STORE, taken BRANCH, JUMP, then untaken BRANCH wraps the 2-bit count
        do_reset;
        start;
        do_instr(4'hB, 0, 0, 1'b0, 0, 4);
        do_instr(4'hE, 0, 0, 1'b1, 1, 3);
        do_instr(4'hD, 0, 0, 1'b0, 2, 3);
        check("sbj_retired", o_retired, 3);
        do_instr(4'hE, 0, 0, 1'b0, 0, 3);
        check("wrap_retired", o_retired, 0);

        // reset mid-MEM of a LOAD
        i_imem_ack = 1'b1; tick;
        i_imem_ack = 1'b0; i_opcode = 4'hC; tick; tick;
        #1;
        check("rmem_state", o_state, 4);
        check("rmem_req", o_dmem_req, 1);
        i_rst = 1'b1; tick;
        i_rst = 1'b0;
        #1;
        check("rmem_post_state", o_state, 0);
        check("rmem_post_outs", outs, 0);
        tick;
        #1;
        check("rmem_idle_hold", o_state, 0);

        // FETCH watchdog: ack withheld for 4 request cycles
        do_reset;
        start;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("wd_f_state", o_state, 1);
            check("wd_f_req", o_imem_req, 1);
            tick;
        end
        #1;
        check("wd_f_fault_state", o_state, 7);
        check("wd_f_fault", o_fault, 1);
        check("wd_f_req_drop", o_imem_req, 0);
        check("wd_f_busy", o_busy, 0);
        check("wd_f_retired", o_retired, 0);
        i_imem_ack = 1'b1; i_run = 1'b1;
        tick; tick;
        #1;
        check("wd_f_terminal", o_state, 7);
        i_imem_ack = 1'b0; i_run = 1'b0;

        // ack on the 4th request cycle is accepted
        do_reset;
        start;
        do_instr(4'hA, 3, 0, 1'b0, 0, 7);
        check("ack4_fault", o_fault, 0);
        check("ack4_retired", o_retired, 1);

        // MEM watchdog on a STORE
        do_reset;
        start;
        i_imem_ack = 1'b1; tick;
        i_imem_ack = 1'b0; i_opcode = 4'hB; tick; tick;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("wd_m_state", o_state, 4);
            check("wd_m_req", o_dmem_req, 1);
            tick;
        end
        #1;
        check("wd_m_fault_state", o_state, 7);
        check("wd_m_req_drop", o_dmem_req, 0);
        check("wd_m_retired", o_retired, 0);

        // two ALU ops then HALT
        do_reset;
        start;
        do_instr(4'h3, 0, 0, 1'b0, 0, 4);
        do_instr(4'h9, 0, 0, 1'b0, 0, 4);
        check("pre_halt_retired", o_retired, 2);
        do_instr(4'hF, 0, 0, 1'b0, 0, 2);
        check("halt_retired", o_retired, 3);
        i_run = 1'b1; i_imem_ack = 1'b1; i_dmem_ack = 1'b1;
        tick; tick; tick;
        #1;
        check("halt_hold_state", o_state, 6);
        check("halt_hold_retired", o_retired, 3);
        check("halt_hold_req", o_imem_req, 0);
        check("halt_hold_halted", o_halted, 1);
        check("halt_hold_busy", o_busy, 0);
        i_run = 1'b0; i_imem_ack = 1'b0; i_dmem_ack = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
